// File: rtl/mbr_mem_if.sv
// Memory buffer register with a memory-side read/write handshake.
// Holds a 16-bit word for the buffer register and moves it to and from memory under a bounded wait.
module mbr_mem_if #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] CON,
  input  logic [7:0]  MAR_IN,
  input  logic [15:0] ACC_IN,
  input  logic [15:0] MEM_RDATA,
  input  logic        MEM_ACK,
  output logic [7:0]  MEM_ADDR,
  output logic [15:0] MEM_WDATA,
  output logic        MEM_RD,
  output logic        MEM_WR,
  output logic [15:0] MBR_OUT,
  output logic        BUSY,
  output logic        ERR
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;

  // Counter value on the last permitted wait edge; reaching it without an ack aborts.
  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

  logic [1:0] state;
  logic [3:0] cnt;

  logic cmd_acc;
  logic cmd_rd;
  logic cmd_wr;
  logic cmd_bad;
  logic cnt_expired;

  // Only CON[4:2] carry meaning for this block.
  logic unused_con;
  assign unused_con = ^{CON[31:5], CON[1:0]};

  assign cmd_bad     = CON[3] & CON[4];
  assign cmd_rd      = CON[3] & ~CON[4];
  assign cmd_wr      = CON[4] & ~CON[3];
  assign cmd_acc     = CON[2] & ~CON[3] & ~CON[4];
  assign cnt_expired = (cnt == CNT_LAST);

  assign MEM_WDATA = MBR_OUT;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: every register, including the data word, is reset so the block comes up fully defined.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= S_IDLE;
      cnt      <= '0;
      MBR_OUT  <= '0;
      MEM_ADDR <= '0;
      MEM_RD   <= 1'b0;
      MEM_WR   <= 1'b0;
      BUSY     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_bad) begin
            ERR <= 1'b1;
          end else if (cmd_rd) begin
            MEM_ADDR <= MAR_IN;
            MEM_RD   <= 1'b1;
            BUSY     <= 1'b1;
            cnt      <= '0;
            ERR      <= 1'b0;
            state    <= S_RD;
          end else if (cmd_wr) begin
            MEM_ADDR <= MAR_IN;
            MEM_WR   <= 1'b1;
            BUSY     <= 1'b1;
            cnt      <= '0;
            ERR      <= 1'b0;
            state    <= S_WR;
          end else if (cmd_acc) begin
            MBR_OUT <= ACC_IN;
            ERR     <= 1'b0;
          end
        end

        S_RD, S_WR: begin
          if (MEM_ACK) begin
            if (state == S_RD) begin
              MBR_OUT <= MEM_RDATA;
            end
            MEM_RD <= 1'b0;
            MEM_WR <= 1'b0;
            BUSY   <= 1'b0;
            state  <= S_IDLE;
          end else if (cnt_expired) begin
            MEM_RD <= 1'b0;
            MEM_WR <= 1'b0;
            BUSY   <= 1'b0;
            ERR    <= 1'b1;
            state  <= S_IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        default: begin
          MEM_RD <= 1'b0;
          MEM_WR <= 1'b0;
          BUSY   <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mbr_mem_if.sv
// Self-checking bench for mbr_mem_if: a transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mbr_mem_if;

  localparam int unsigned TIMEOUT = 15;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] CON = '0;
  logic [7:0]  MAR_IN = '0;
  logic [15:0] ACC_IN = '0;
  logic [15:0] MEM_RDATA = '0;
  logic        MEM_ACK = 1'b0;
  logic [7:0]  MEM_ADDR;
  logic [15:0] MEM_WDATA;
  logic        MEM_RD;
  logic        MEM_WR;
  logic [15:0] MBR_OUT;
  logic        BUSY;
  logic        ERR;

  int n_checks = 0;
  int n_errors = 0;

  mbr_mem_if #(.TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .CON(CON), .MAR_IN(MAR_IN), .ACC_IN(ACC_IN),
    .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR),
    .MBR_OUT(MBR_OUT), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one pending transaction kind plus edges elapsed since it was accepted.
  typedef enum int {T_NONE, T_READ, T_WRITE} txn_e;
  txn_e        m_txn = T_NONE;
  int          m_elapsed = 0;
  logic [15:0] m_mbr = '0;
  logic [7:0]  m_addr = '0;
  logic        m_err = 1'b0;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_txn = T_NONE; m_elapsed = 0; m_mbr = '0; m_addr = '0; m_err = 1'b0;
    end else if (m_txn == T_NONE) begin
      if (CON[3] && CON[4]) m_err = 1'b1;
      else if (CON[3] || CON[4]) begin
        m_txn = CON[3] ? T_READ : T_WRITE;
        m_addr = MAR_IN; m_elapsed = 0; m_err = 1'b0;
      end else if (CON[2]) begin
        m_mbr = ACC_IN; m_err = 1'b0;
      end
    end else begin
      m_elapsed++;
      if (MEM_ACK) begin
        if (m_txn == T_READ) m_mbr = MEM_RDATA;
        m_txn = T_NONE;
      end else if (m_elapsed == int'(TIMEOUT)) begin
        m_txn = T_NONE; m_err = 1'b1;
      end
    end
  end

  bit compare_on = 1'b0;
  always @(negedge CLK) begin
    if (compare_on) begin
      check("model MBR_OUT", 32'(MBR_OUT), 32'(m_mbr));
      check("model MEM_WDATA", 32'(MEM_WDATA), 32'(m_mbr));
      check("model MEM_ADDR", 32'(MEM_ADDR), 32'(m_addr));
      check("model MEM_RD", 32'(MEM_RD), 32'(m_txn == T_READ));
      check("model MEM_WR", 32'(MEM_WR), 32'(m_txn == T_WRITE));
      check("model BUSY", 32'(BUSY), 32'(m_txn != T_NONE));
      check("model ERR", 32'(ERR), 32'(m_err));
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  int rd_cycles;

  initial begin
    compare_on = 1'b1;
    // Reset and ACC load
    cyc(); cyc();
    check("reset MBR_OUT", 32'(MBR_OUT), 32'h0);
    check("reset BUSY", 32'(BUSY), 32'h0);
    RST = 1'b1;
    cyc();
    ACC_IN = 16'hA5A5; CON = 32'h4;
    cyc();
    CON = '0;
    check("acc load MBR_OUT", 32'(MBR_OUT), 32'hA5A5);
    check("acc load BUSY", 32'(BUSY), 32'h0);

    // Read with 3 wait cycles, ack on the 4th RD edge
    MAR_IN = 8'h3C; CON = 32'h8;
    cyc();
    CON = '0;
    check("read MEM_ADDR", 32'(MEM_ADDR), 32'h3C);
    rd_cycles = 0;
    for (int i = 1; i <= 4; i++) begin
      if (MEM_RD) rd_cycles++;
      if (i == 4) begin MEM_ACK = 1'b1; MEM_RDATA = 16'h1234; end
      cyc();
    end
    MEM_ACK = 1'b0;
    check("read MEM_RD cycles", 32'(rd_cycles), 32'd4);
    check("read MEM_RD after ack", 32'(MEM_RD), 32'h0);
    check("read MBR_OUT", 32'(MBR_OUT), 32'h1234);
    check("read BUSY", 32'(BUSY), 32'h0);
    check("read ERR", 32'(ERR), 32'h0);

    // Write, acked on the first WR edge
    ACC_IN = 16'hBEEF; CON = 32'h4;
    cyc();
    MAR_IN = 8'h07; CON = 32'h10;
    cyc();
    CON = '0;
    MEM_ACK = 1'b1;
    check("write MEM_WR", 32'(MEM_WR), 32'h1);
    check("write MEM_WDATA", 32'(MEM_WDATA), 32'hBEEF);
    check("write MEM_ADDR", 32'(MEM_ADDR), 32'h07);
    cyc();
    MEM_ACK = 1'b0;
    check("write MEM_WR after ack", 32'(MEM_WR), 32'h0);
    check("write MBR_OUT", 32'(MBR_OUT), 32'hBEEF);

    // Timeout: no ack ever
    MAR_IN = 8'h55; CON = 32'h8;
    cyc();
    CON = '0;
    for (int i = 1; i < int'(TIMEOUT); i++) cyc();
    check("timeout BUSY before last edge", 32'(BUSY), 32'h1);
    cyc();
    check("timeout MEM_RD", 32'(MEM_RD), 32'h0);
    check("timeout BUSY", 32'(BUSY), 32'h0);
    check("timeout ERR", 32'(ERR), 32'h1);
    check("timeout MBR_OUT", 32'(MBR_OUT), 32'hBEEF);
    ACC_IN = 16'h0F0F; CON = 32'h4;
    cyc();
    CON = '0;
    check("acc clears ERR", 32'(ERR), 32'h0);
    check("acc after timeout MBR_OUT", 32'(MBR_OUT), 32'h0F0F);

    // Illegal command
    ACC_IN = 16'h5555; CON = 32'h1C;
    cyc();
    CON = '0;
    check("illegal ERR", 32'(ERR), 32'h1);
    check("illegal BUSY", 32'(BUSY), 32'h0);
    check("illegal MEM_RD", 32'(MEM_RD), 32'h0);
    check("illegal MEM_WR", 32'(MEM_WR), 32'h0);
    check("illegal MBR_OUT", 32'(MBR_OUT), 32'h0F0F);

    // ACC load requested mid-read is ignored
    MAR_IN = 8'hA0; CON = 32'h8;
    cyc();
    check("read clears ERR", 32'(ERR), 32'h0);
    ACC_IN = 16'hFFFF; CON = 32'h4;
    cyc(); cyc();
    check("mid-read MBR_OUT", 32'(MBR_OUT), 32'h0F0F);
    CON = '0; MEM_ACK = 1'b1; MEM_RDATA = 16'hCAFE;
    cyc();
    MEM_ACK = 1'b0;
    check("mid-read final MBR_OUT", 32'(MBR_OUT), 32'hCAFE);

    // Back-to-back read accepted right after BUSY falls, then reset two cycles into RD
    MAR_IN = 8'h11; CON = 32'h8;
    cyc();
    CON = '0;
    cyc(); cyc();
    check("pre-reset MEM_RD", 32'(MEM_RD), 32'h1);
    RST = 1'b0;
    #1;
    check("async reset MEM_RD", 32'(MEM_RD), 32'h0);
    check("async reset BUSY", 32'(BUSY), 32'h0);
    check("async reset MBR_OUT", 32'(MBR_OUT), 32'h0);
    check("async reset MEM_ADDR", 32'(MEM_ADDR), 32'h0);
    cyc();
    RST = 1'b1;
    MEM_ACK = 1'b1; MEM_RDATA = 16'h9999;
    cyc(); cyc();
    MEM_ACK = 1'b0;
    check("late ack MBR_OUT", 32'(MBR_OUT), 32'h0);
    check("late ack BUSY", 32'(BUSY), 32'h0);
    cyc();

    compare_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
